traffic_phase_arbiter: RTL and testbench

TRAFFIC_PHASE_ARBITER -- requirements
Module: traffic_phase_arbiter

---
 rtl/traffic_phase_arbiter.sv | 152 +++++++++++++++
 tb/tb_traffic_phase_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_arbiter.sv
// Four-approach traffic phase arbiter: round-robin green grants with min/max green
// hold, fixed yellow and all-red clearance, and emergency preemption.
module traffic_phase_arbiter #(
   parameter int GREEN_MIN = 8,
   parameter int GREEN_MAX = 32,
   parameter int YELLOW_T  = 4,
   parameter int CLEAR_T   = 2,
   parameter int CW        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       preempt,
   input  logic [1:0] preempt_dir,
   output logic [3:0] green,
   output logic [3:0] yellow,
   output logic [3:0] red,
   output logic [1:0] active_dir,
   output logic [1:0] phase,
   output logic [3:0] pending
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GREEN  = 2'd1,
      S_YELLOW = 2'd2,
      S_CLEAR  = 2'd3
   } phase_e;

   localparam logic [CW-1:0] GMIN_LAST = CW'(GREEN_MIN - 1);
   localparam logic [CW-1:0] GMAX_LAST = CW'(GREEN_MAX - 1);
   localparam logic [CW-1:0] YEL_LAST  = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR_T - 1);
   localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   phase_e        phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    pending_q, pending_d;
   logic [1:0]    active_q, active_d;
   logic [3:0]    green_q, green_d;
   logic [3:0]    yellow_q, yellow_d;
   logic [3:0]    red_q, red_d;

   logic       rr_found;
   logic [1:0] rr_dir;
   logic [3:0] active_oh;
   logic       others_pending;
   logic       enter_green;
   logic [1:0] grant_dir;

   // Round-robin search starts just after the most recently served approach.
   always_comb begin
      rr_found = 1'b0;
      rr_dir   = active_q;
      for (int k = 1; k <= 4; k++) begin
         if (!rr_found && pending_q[active_q + 2'(k)]) begin
            rr_found = 1'b1;
            rr_dir   = active_q + 2'(k);
         end
      end
   end

   assign active_oh      = 4'b0001 << active_q;
   assign others_pending = |(pending_q & ~active_oh);

   always_comb begin
      phase_d     = phase_q;
      active_d    = active_q;
      enter_green = 1'b0;
      grant_dir   = rr_dir;
      case (phase_q)
         S_IDLE: begin
            if (preempt) begin
               enter_green = 1'b1;
               grant_dir   = preempt_dir;
            end else if (rr_found) begin
               enter_green = 1'b1;
            end
         end
         S_GREEN: begin
            if (preempt) begin
               if (preempt_dir != active_q) phase_d = S_YELLOW;
            end else if (cnt_q >= GMIN_LAST && others_pending &&
                         (!req[active_q] || cnt_q >= GMAX_LAST)) begin
               phase_d = S_YELLOW;
            end
         end
         S_YELLOW: begin
            if (cnt_q == YEL_LAST) phase_d = S_CLEAR;
         end
         S_CLEAR: begin
            if (cnt_q == CLR_LAST) begin
               if (preempt) begin
                  enter_green = 1'b1;
                  grant_dir   = preempt_dir;
               end else if (rr_found) begin
                  enter_green = 1'b1;
               end else begin
                  phase_d = S_IDLE;
               end
            end
         end
         default: phase_d = S_IDLE;
      endcase

      if (enter_green) begin
         phase_d  = S_GREEN;
         active_d = grant_dir;
      end

      // Demand from the approach currently holding green is not latched.
      pending_d = pending_q | (req & ((phase_q == S_GREEN) ? ~active_oh : 4'hF));
      if (enter_green) pending_d[grant_dir] = 1'b0;

      if (phase_d != phase_q)  cnt_d = '0;
      else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
      else                     cnt_d = cnt_q;

      green_d  = (phase_d == S_GREEN)  ? (4'b0001 << active_d) : 4'b0000;
      yellow_d = (phase_d == S_YELLOW) ? (4'b0001 << active_d) : 4'b0000;
      red_d    = ~(green_d | yellow_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q   <= S_IDLE;
         cnt_q     <= '0;
         pending_q <= 4'h0;
         active_q  <= 2'd3;
         green_q   <= 4'h0;
         yellow_q  <= 4'h0;
         red_q     <= 4'hF;
      end else begin
         phase_q   <= phase_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         active_q  <= active_d;
         green_q   <= green_d;
         yellow_q  <= yellow_d;
         red_q     <= red_d;
      end
   end

   assign green      = green_q;
   assign yellow     = yellow_q;
   assign red        = red_q;
   assign active_dir = active_q;
   assign phase      = phase_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter: directed timing scenarios plus randomized demand,
// all checked cycle by cycle against an integer-level model of the phase rules.
module tb_traffic_phase_arbiter;

   localparam int GMIN = 8;
   localparam int GMAX = 32;
   localparam int YT   = 4;
   localparam int CT   = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       preempt;
   logic [1:0] preempt_dir;
   logic [3:0] green, yellow, red, pending;
   logic [1:0] active_dir, phase;
   logic [19:0] dut_vec;

   int checks = 0;
   int errors = 0;

   // Model state: phase code, cycles spent in phase, served approach, latched demand.
   int         m_phase, m_t, m_dir;
   logic [3:0] m_pend;

   traffic_phase_arbiter #(
      .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .CLEAR_T(CT), .CW(16)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .preempt(preempt), .preempt_dir(preempt_dir),
      .green(green), .yellow(yellow), .red(red), .active_dir(active_dir),
      .phase(phase), .pending(pending)
   );

   always #5 clk = ~clk;

   assign dut_vec = {green, yellow, red, phase, active_dir, pending};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [19:0] exp_vec();
      logic [3:0] g, y;
      g = (m_phase == 1) ? 4'(1 << m_dir) : 4'h0;
      y = (m_phase == 2) ? 4'(1 << m_dir) : 4'h0;
      return {g, y, ~(g | y), 2'(m_phase), 2'(m_dir), m_pend};
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_t     = 0;
      m_dir   = 3;
      m_pend  = 4'h0;
   endtask

   // Advance one clock; the model consumes the inputs present at the edge.
   task automatic tick();
      int np, nd, nt, sel;
      bit found, others, go;
      logic [3:0] npend;
      if (reset) begin
         @(posedge clk);
         #1;
         return;
      end
      found = 0;
      sel   = m_dir;
      for (int k = 1; k <= 4; k++) begin
         int j;
         j = (m_dir + k) % 4;
         if (!found && m_pend[j]) begin
            found = 1;
            sel   = j;
         end
      end
      others = 0;
      for (int j = 0; j < 4; j++) if (j != m_dir && m_pend[j]) others = 1;
      np = m_phase;
      nd = m_dir;
      go = 0;
      case (m_phase)
         0: begin
            if (preempt) begin go = 1; nd = int'(preempt_dir); end
            else if (found) begin go = 1; nd = sel; end
         end
         1: begin
            if (preempt) begin
               if (int'(preempt_dir) != m_dir) np = 2;
            end else if (m_t >= GMIN - 1 && others && (!req[m_dir] || m_t >= GMAX - 1)) begin
               np = 2;
            end
         end
         2: if (m_t == YT - 1) np = 3;
         default: begin
            if (m_t == CT - 1) begin
               if (preempt) begin go = 1; nd = int'(preempt_dir); end
               else if (found) begin go = 1; nd = sel; end
               else np = 0;
            end
         end
      endcase
      if (go) np = 1;
      npend = m_pend;
      for (int i = 0; i < 4; i++) if (req[i] && !(m_phase == 1 && i == m_dir)) npend[i] = 1'b1;
      if (go) npend[nd] = 1'b0;
      nt = (np != m_phase) ? 0 : m_t + 1;
      @(posedge clk);
      #1;
      m_phase = np;
      m_dir   = nd;
      m_pend  = npend;
      m_t     = nt;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      req         = 4'h0;
      preempt     = 1'b0;
      preempt_dir = 2'd0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      req         = 4'h0;
      preempt     = 1'b0;
      preempt_dir = 2'd0;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== {4'h0, 4'h0, 4'hF, 2'd0, 2'd3, 4'h0}) begin
         errors++;
         $display("FAIL reset_state: got %h, required %h", dut_vec, {4'h0, 4'h0, 4'hF, 2'd0, 2'd3, 4'h0});
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      checks++;
      if (dut_vec !== {4'h0, 4'h0, 4'hF, 2'd0, 2'd3, 4'h0}) begin
         errors++;
         $display("FAIL reset_idle_hold: got %h, required %h", dut_vec, {4'h0, 4'h0, 4'hF, 2'd0, 2'd3, 4'h0});
      end
   endtask

   task automatic test_single_request();
      do_reset();
      req = 4'b0100;
      tick();
      req = 4'h0;
      checks++;
      if (pending !== 4'b0100 || green !== 4'h0) begin
         errors++;
         $display("FAIL single_pending: got pending=%b green=%b, required pending=0100 green=0000", pending, green);
      end
      tick();
      checks++;
      if (green !== 4'b0100 || phase !== 2'd1) begin
         errors++;
         $display("FAIL single_grant: got green=%b phase=%0d, required green=0100 phase=1", green, phase);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL single_model cyc=%0d: got %h, required %h", i, dut_vec, exp_vec());
         end
      end
      checks++;
      if (green !== 4'b0100 || phase !== 2'd1) begin
         errors++;
         $display("FAIL single_rest: got green=%b phase=%0d, required green=0100 phase=1", green, phase);
      end
   endtask

   task automatic test_max_green();
      int g0, y0, ar, g1_first;
      do_reset();
      req = 4'b0001;
      tick();
      tick();
      checks++;
      if (green !== 4'b0001) begin
         errors++;
         $display("FAIL maxg_entry: got green=%b, required 0001", green);
      end
      g0 = 1; y0 = 0; ar = 0; g1_first = -1;
      for (int i = 1; i <= 40; i++) begin
         req = (i == 1) ? 4'b0011 : 4'b0001;
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL maxg_model cyc=%0d: got %h, required %h", i, dut_vec, exp_vec());
         end
         if (green == 4'b0001) g0++;
         else if (yellow == 4'b0001) y0++;
         else if (green == 4'h0 && yellow == 4'h0 && g1_first < 0) ar++;
         if (green == 4'b0010 && g1_first < 0) g1_first = i;
      end
      req = 4'h0;
      checks++;
      if (g0 != 32 || y0 != 4 || ar != 2 || g1_first != 38) begin
         errors++;
         $display("FAIL maxg_timing: got green=%0d yellow=%0d allred=%0d g1_at=%0d, required 32 4 2 38",
                  g0, y0, ar, g1_first);
      end
   endtask

   task automatic test_min_green();
      int g0, y_first;
      do_reset();
      req = 4'b0001;
      tick();
      req = 4'h0;
      tick();
      g0 = 1; y_first = -1;
      for (int i = 1; i <= 20; i++) begin
         req = (i == 1) ? 4'b1000 : 4'h0;
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL ming_model cyc=%0d: got %h, required %h", i, dut_vec, exp_vec());
         end
         if (green == 4'b0001) g0++;
         if (yellow == 4'b0001 && y_first < 0) y_first = i;
      end
      req = 4'h0;
      checks++;
      if (g0 != 8 || y_first != 8) begin
         errors++;
         $display("FAIL ming_timing: got green=%0d yellow_at=%0d, required 8 8", g0, y_first);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_q[$];
      logic [1:0] d, want;
      logic [3:0] prev_g;
      int gap, grants;
      do_reset();
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      req = 4'hF;
      prev_g = 4'h0; gap = 0; grants = 0;
      for (int i = 0; i < 400 && grants < 5; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL rr_model cyc=%0d: got %h, required %h", i, dut_vec, exp_vec());
         end
         if (green != 4'h0 && prev_g == 4'h0) begin
            d = green[0] ? 2'd0 : green[1] ? 2'd1 : green[2] ? 2'd2 : 2'd3;
            want = exp_q.pop_front();
            checks++;
            if (d !== want) begin
               errors++;
               $display("FAIL rr_order grant=%0d: got dir %0d, required %0d", grants, d, want);
            end
            if (grants > 0) begin
               checks++;
               if (gap != YT + CT) begin
                  errors++;
                  $display("FAIL rr_gap grant=%0d: got %0d cycles, required %0d", grants, gap, YT + CT);
               end
            end
            grants++;
            gap = 0;
         end else if (green == 4'h0 && grants > 0) begin
            gap++;
         end
         prev_g = green;
      end
      req = 4'h0;
      checks++;
      if (grants != 5) begin
         errors++;
         $display("FAIL rr_timeout: got %0d grants, required 5", grants);
      end
   endtask

   task automatic test_preempt();
      int yc, ar, g3_first;
      do_reset();
      req = 4'b0010;
      tick();
      req = 4'b0001;
      tick();
      req = 4'h0;
      checks++;
      if (green !== 4'b0010 || pending !== 4'b0001) begin
         errors++;
         $display("FAIL pre_setup: got green=%b pending=%b, required 0010 0001", green, pending);
      end
      tick();
      tick();
      preempt = 1'b1;
      preempt_dir = 2'd3;
      yc = 0; ar = 0; g3_first = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL pre_model cyc=%0d: got %h, required %h", i, dut_vec, exp_vec());
         end
         if (i == 1) begin
            checks++;
            if (yellow !== 4'b0010) begin
               errors++;
               $display("FAIL pre_immediate: got yellow=%b, required 0010", yellow);
            end
         end
         if (yellow == 4'b0010) yc++;
         if (green == 4'h0 && yellow == 4'h0) ar++;
         if (green == 4'b1000 && g3_first < 0) g3_first = i;
      end
      checks++;
      if (yc != 4 || ar != 2 || g3_first != 7 || green !== 4'b1000 || pending[0] !== 1'b1) begin
         errors++;
         $display("FAIL pre_sequence: got yellow=%0d allred=%0d g3_at=%0d green=%b pend0=%b, required 4 2 7 1000 1",
                  yc, ar, g3_first, green, pending[0]);
      end
      preempt = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL pre_release cyc=%0d: got %h, required %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid_yellow();
      bit found;
      do_reset();
      req = 4'b0001;
      tick();
      req = 4'b0010;
      tick();
      req = 4'h0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (yellow != 4'h0) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rst_yel_reach: got no yellow within 20 cycles, required yellow");
      end
      tick();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (dut_vec !== {4'h0, 4'h0, 4'hF, 2'd0, 2'd3, 4'h0}) begin
         errors++;
         $display("FAIL rst_async: got %h, required %h", dut_vec, {4'h0, 4'h0, 4'hF, 2'd0, 2'd3, 4'h0});
      end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      req = 4'b1001;
      tick();
      req = 4'h0;
      tick();
      checks++;
      if (green !== 4'b0001 || dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL rst_first_grant: got green=%b vec=%h, required green=0001 vec=%h",
                  green, dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      logic [3:0] mask;
      bit bad;
      do_reset();
      mask = 4'hF;
      for (int i = 0; i < 1500; i++) begin
         if (i % 60 == 0) mask = 4'($urandom_range(0, 15));
         if (i % 12 == 0) begin
            preempt     = ($urandom_range(0, 5) == 0);
            preempt_dir = 2'($urandom_range(0, 3));
         end
         req = 4'($urandom_range(0, 15)) & mask;
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL rand_model cyc=%0d: got %h, required %h", i, dut_vec, exp_vec());
         end
         bad = 0;
         for (int k = 0; k < 4; k++)
            if (int'(green[k]) + int'(yellow[k]) + int'(red[k]) != 1) bad = 1;
         if ($countones(green) > 1) bad = 1;
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL rand_lamps cyc=%0d: got g=%b y=%b r=%b, required one lamp each and <=1 green",
                     i, green, yellow, red);
         end
      end
      preempt = 1'b0;
      req = 4'h0;
   endtask

   initial begin
      test_reset();
      test_single_request();
      test_max_green();
      test_min_green();
      test_round_robin();
      test_preempt();
      test_reset_mid_yellow();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
